// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 key schedule.
// sbox is computed as inverse-then-affine rather than from a table.
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int MAX_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_e;

  typedef logic [127:0] rkey_t;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (0 maps to 0).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] c;
    case (rnd)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_key_schedule_expand.sv
// One combinational AES-128 keyExpansion round step.
// Word 0 sits in bits [127:96].
module aes_key_schedule_expand
  import aes_pkg::*;
(
  input  rkey_t      key_i,
  input  logic [3:0] round_i,
  output rkey_t      key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, tmp;
  logic [31:0] n0, n1, n2, n3;

  assign w0  = key_i[127:96];
  assign w1  = key_i[95:64];
  assign w2  = key_i[63:32];
  assign w3  = key_i[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]),  sbox(rot[7:0])};
  assign tmp = sub ^ {rcon(round_i), 24'h000000};
  assign n0  = w0 ^ tmp;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule with a registered round-key read port.
// Optional KS_ZEROIZE_EN adds a zeroize input and clearable slots.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out,
  output logic             rk_hit
`ifdef KS_ZEROIZE_EN
  ,
  input  logic             zeroize
`endif
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  ks_state_e  state_q, state_d;
  logic [3:0] gen_cnt_q, gen_cnt_d;
  logic [3:0] rnd_q, rnd_d;
  logic       accept, wr_en, zero_w;

  rkey_t slot_q [NUM_ROUNDS+1];
  rkey_t prev_key, next_key, rd_data;

  logic [KEY_W-1:0] rk_out_q;
  logic             rk_hit_q;

`ifdef KS_ZEROIZE_EN
  assign zero_w = zeroize;
`else
  assign zero_w = 1'b0;
`endif

  assign key_ready = (state_q != EXPAND);
  assign busy      = (state_q == EXPAND);
  assign done      = (state_q == DONE);
  assign rk_out    = rk_out_q;
  assign rk_hit    = rk_hit_q;

  // Next state, counters and store write strobes.
  always_comb begin
    state_d   = state_q;
    gen_cnt_d = gen_cnt_q;
    rnd_d     = rnd_q;
    accept    = 1'b0;
    wr_en     = 1'b0;
    if (zero_w) begin
      state_d   = IDLE;
      gen_cnt_d = 4'd0;
      rnd_d     = 4'd1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (key_valid) begin
            accept    = 1'b1;
            state_d   = EXPAND;
            gen_cnt_d = 4'd1;
            rnd_d     = 4'd1;
          end
        end
        EXPAND: begin
          wr_en     = 1'b1;
          gen_cnt_d = gen_cnt_q + 4'd1;
          if (rnd_q == LAST) state_d = DONE;
          else rnd_d = rnd_q + 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gen_cnt_q <= 4'd0;
      rnd_q     <= 4'd1;
    end else begin
      state_q   <= state_d;
      gen_cnt_q <= gen_cnt_d;
      rnd_q     <= rnd_d;
    end
  end

  // Store muxes: expansion source slot and read-port slot.
  always_comb begin
    prev_key = '0;
    rd_data  = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rk_idx == 4'(i)) rd_data = slot_q[i];
      if (rnd_q == 4'(i + 1)) prev_key = slot_q[i];
    end
  end

  aes_key_schedule_expand u_expand (
    .key_i   (prev_key),
    .round_i (rnd_q),
    .key_o   (next_key)
  );

`ifdef KS_ZEROIZE_EN
  // Round-key store, cleared by reset or zeroize.
  always_ff @(posedge clk) begin
    if (rst || zero_w) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
    end else begin
      if (accept) slot_q[0] <= key_in;
      for (int i = 1; i <= NUM_ROUNDS; i++)
        if (wr_en && rnd_q == 4'(i)) slot_q[i] <= next_key;
    end
  end
`else
  // Round-key store; plain registers, made unreachable by gen_cnt on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) slot_q[0] <= key_in;
      for (int i = 1; i <= NUM_ROUNDS; i++)
        if (wr_en && rnd_q == 4'(i)) slot_q[i] <= next_key;
    end
  end
`endif

  // Registered read port using the pre-edge valid count.
  always_ff @(posedge clk) begin
    if (rst || zero_w) begin
      rk_out_q <= '0;
      rk_hit_q <= 1'b0;
    end else begin
      rk_out_q <= rd_data;
      rk_hit_q <= (rk_idx < gen_cnt_q);
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule with a FIPS-197 reference model.
// Define KS_ZEROIZE_EN to also exercise the zeroize port.
module tb_aes_key_schedule;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, done, rk_hit;
  logic [127:0] key_in = '0;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx = '0;
`ifdef KS_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_key_schedule #(.KEY_W(128), .NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out),
    .rk_hit    (rk_hit)
`ifdef KS_ZEROIZE_EN
    ,
    .zeroize   (zeroize)
`endif
  );

  typedef struct {
    logic         rdy;
    logic         bsy;
    logic         dn;
    logic         hit;
    logic [127:0] dat;
    bit           chk;
  } exp_t;

  exp_t sq[$];
  exp_t me;
  int tests = 0;
  int fails = 0;

  logic [7:0]   sbt [256];
  logic [127:0] ks  [NR+1];
  bit           have = 0;
  int           acc_n = 0;
  int           cyc = 0;

  localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  function automatic int gm(input int a, input int b);
    int r = 0;
    int aa = a;
    int bb = b;
    while (bb != 0) begin
      if ((bb & 1) != 0) r = r ^ aa;
      aa = aa << 1;
      if ((aa & 256) != 0) aa = aa ^ 283;
      bb = bb >> 1;
    end
    return r;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] a, b, c;
      a = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(x, y) == 1) a = 8'(y);
      c = 8'h63;
      for (int i = 0; i < 8; i++)
        b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8]
             ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
      sbt[x] = b;
    end
  endtask

  // FIPS-197 word-oriented expansion into the model key set.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] t;
    int rc;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
        t = t ^ {8'(rc), 24'h0};
        rc = gm(rc, 2);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic cmpb(input string nm, input logic act, input logic ex);
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s got %b want %b (t=%0t)", nm, act, ex, $time);
    end
  endtask

  task automatic cmpw(input string nm, input logic [127:0] act,
                      input logic [127:0] ex);
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  // One clock: drive inputs, predict the post-edge response, advance.
  task automatic step(input bit v, input logic [127:0] k,
                      input logic [3:0] idx, input bit r, input bit z);
    exp_t e;
    int en, nv;
    bit rdy;
    @(negedge clk);
    rst = r;
    key_valid = v;
    key_in = k;
    rk_idx = idx;
`ifdef KS_ZEROIZE_EN
    zeroize = z;
`endif
    en  = cyc + 1;
    rdy = !have || (en - 1 - acc_n) >= NR;
    nv  = 0;
    if (have) nv = (en - acc_n > NR + 1) ? NR + 1 : en - acc_n;
    e.hit = !r && !z && (int'(idx) < nv);
    if (r || z || int'(idx) > NR) e.dat = '0;
    else e.dat = ks[idx];
    e.chk = r || z || int'(idx) > NR || e.hit;
    if (r || z) have = 0;
    else if (v && rdy) begin
      have  = 1;
      acc_n = en;
      expand(k);
    end
    e.bsy = have && (en - acc_n) < NR;
    e.dn  = have && (en - acc_n) >= NR;
    e.rdy = !e.bsy;
    sq.push_back(e);
    cyc = en;
    @(posedge clk);
  endtask

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compare every registered output after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (sq.size() > 0) begin
      me = sq.pop_front();
      cmpb("key_ready", key_ready, me.rdy);
      cmpb("busy", busy, me.bsy);
      cmpb("done", done, me.dn);
      cmpb("rk_hit", rk_hit, me.hit);
      if (me.chk) cmpw("rk_out", rk_out, me.dat);
    end
  end

  initial begin
    build_sbox();
    step(0, '0, 4'd0, 1, 0);
    step(0, '0, 4'd3, 1, 0);
    step(0, '0, 4'd0, 0, 0);

    // FIPS key, polling index 5 through expansion.
    step(1, FIPS_K, 4'd5, 0, 0);
    for (int i = 0; i < NR + 1; i++) step(0, '0, 4'd5, 0, 0);
    step(0, '0, 4'd1, 0, 0);
    #2 cmpw("fips_rk1", rk_out, FIPS_R1);
    step(0, '0, 4'd10, 0, 0);
    #2 cmpw("fips_rk10", rk_out, FIPS_R10);

    // New key from DONE, read index 0 from acceptance on.
    step(1, rkey(), 4'd10, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 4'd0, 0, 0);

    // key_valid held high through EXPAND, then all-zero key in DONE.
    for (int i = 0; i < NR - 4; i++) step(1, rkey(), 4'($urandom % 11), 0, 0);
    step(1, '0, 4'd10, 0, 0);
    for (int i = 0; i < NR; i++) step(0, rkey(), 4'd10, 0, 0);
    step(0, '0, 4'd10, 0, 0);
    #2 cmpw("zero_rk10", rk_out, ZERO_R10);

    // Out-of-range indices in DONE.
    for (int i = 11; i < 16; i++) step(0, '0, 4'(i), 0, 0);

    // Reset on the 4th expansion cycle, then sweep all indices.
    step(1, rkey(), 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 4'd0, 0, 0);
    step(0, '0, 4'd1, 1, 0);
    for (int i = 0; i < 16; i++) step(0, '0, 4'(i), 0, 0);

`ifdef KS_ZEROIZE_EN
    step(1, rkey(), 4'd0, 0, 0);
    for (int i = 0; i < NR; i++) step(0, '0, 4'd0, 0, 0);
    step(1, rkey(), 4'd3, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 4'(i), 0, 0);
      #2 cmpw("zeroize_data", rk_out, '0);
    end
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bit z;
      z = 0;
`ifdef KS_ZEROIZE_EN
      z = ($urandom % 60) == 0;
`endif
      step(($urandom % 4) == 0, rkey(), 4'($urandom % 16),
           ($urandom % 80) == 0, z);
    end

    #3;
    cmpb("scoreboard_drained", sq.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
